// File: rtl/rice_encoder_serial_pkg.sv
// rice_encoder_serial_pkg: widths, FSM encoding and codeword constants
// shared by the Rice encoder and its decoder counterpart.
package rice_encoder_serial_pkg;
    localparam int DW   = 16;
    localparam int KW   = 6;
    localparam int QMAX = 32;
    localparam int LW   = $clog2(DW + 1);
    localparam int QW   = $clog2(QMAX + 2);
    // Codewords travel MSB-first on the wire, matching the decoder.
    localparam bit CW_MSB_FIRST = 1'b1;
    typedef enum logic [2:0] {IDLE, UNARY, STOP, ESC, REM, DONE} state_t;
    function automatic int esc_bit_len(input int qmax, input int dw);
        return qmax + 2 + dw;
    endfunction
endpackage

// File: rtl/rice_encoder_serial_if.sv
// rice_encoder_serial_if: sample-in and bit-out handshake bundle.
interface rice_encoder_serial_if;
    import rice_encoder_serial_pkg::*;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic [KW-1:0] k;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          cw_last;
    modport master (
        output in_valid, data_in, k, bit_ready,
        input  in_ready, bit_out, bit_valid, cw_last
    );
    modport slave (
        input  in_valid, data_in, k, bit_ready,
        output in_ready, bit_out, bit_valid, cw_last
    );
endinterface

// File: rtl/rice_bit_serializer.sv
// rice_bit_serializer: holds a right-aligned N-bit field and emits it
// MSB-first, one bit per advance, flagging the last bit.
module rice_bit_serializer #(
    parameter int DW = 16,
    parameter int LW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [LW-1:0] load_len,
    input  logic          adv,
    output logic          bit_out,
    output logic          last,
    output logic          active
);
    logic [DW-1:0] data_q, data_d;
    logic [LW-1:0] cnt_q, cnt_d;
    always_comb begin
        data_d = load ? load_data : data_q;
        cnt_d  = load ? load_len : ((adv && cnt_q != '0) ? cnt_q - LW'(1) : cnt_q);
    end
    // cnt_q counts bits still to send, so the current bit sits at cnt_q-1.
    assign bit_out = |(data_q & (DW'(1) << (cnt_q - LW'(1))));
    assign last    = cnt_q == LW'(1);
    assign active  = cnt_q != '0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/rice_encoder_serial.sv
// rice_encoder_serial: Rice/Golomb-2^k encoder emitting q zeros, a stop '1'
// and k remainder bits serially; quotients above QMAX take the escape code.
module rice_encoder_serial
    import rice_encoder_serial_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    output logic busy,
    output logic done,
    rice_encoder_serial_if.slave bus
);
    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic [LW-1:0] keff, ser_len;
    logic [DW-1:0] q;
    logic          esc, acc, xfer, ser_adv, ser_bit, ser_last, ser_active;
    assign bus.in_ready  = reset_n && state_q == IDLE && start;
    assign bus.bit_valid = state_q inside {UNARY, ESC, STOP, REM};
    assign bus.bit_out   = state_q == STOP || (state_q == REM && ser_bit);
    assign bus.cw_last   = (state_q == STOP && !ser_active) || (state_q == REM && ser_last);
    assign busy          = bus.bit_valid;
    assign done          = state_q == DONE;
    always_comb begin
        keff    = (bus.k > KW'(DW)) ? LW'(DW) : LW'(bus.k);
        q       = bus.data_in >> keff;
        esc     = q > DW'(QMAX);
        acc     = bus.in_valid && bus.in_ready;
        xfer    = bus.bit_valid && bus.bit_ready;
        ser_len = esc ? LW'(DW) : keff;
        ser_adv = xfer && state_q == REM;
    end
    // The escape path reuses STOP/REM: QMAX+1 zeros, then '1', then the raw field.
    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        stop_pend_d = stop_pend_q || (stop && (state_q != IDLE || acc));
        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = esc ? ESC : (q != '0 ? UNARY : STOP);
                    qcnt_d  = esc ? QW'(QMAX + 1) : QW'(q);
                end else if (stop && !bus.in_valid) begin
                    state_d = DONE;
                end
            end
            UNARY, ESC: begin
                if (xfer) begin
                    qcnt_d  = qcnt_q - QW'(1);
                    state_d = qcnt_q == QW'(1) ? STOP : state_q;
                end
            end
            STOP: if (xfer) state_d = ser_active ? REM : (stop_pend_d ? DONE : IDLE);
            REM:  if (xfer && ser_last) state_d = stop_pend_d ? DONE : IDLE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            qcnt_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end
    rice_bit_serializer #(.DW(DW), .LW(LW)) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (acc),
        .load_data (bus.data_in),
        .load_len  (ser_len),
        .adv       (ser_adv),
        .bit_out   (ser_bit),
        .last      (ser_last),
        .active    (ser_active)
    );
endmodule

// File: tb/tb_rice_encoder_serial.sv
// tb_rice_encoder_serial: table-driven codeword checks plus hand-written
// stop, stall and mid-codeword reset sequences.
module tb_rice_encoder_serial;
    import rice_encoder_serial_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic busy, done;
    int n_cmp = 0, n_bad = 0;
    rice_encoder_serial_if bus();
    rice_encoder_serial dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .busy    (busy),
        .done    (done),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] d;
        logic [5:0]  k;
        bit          stall;
        int          len;
        logic [63:0] bits;
    } vec_t;
    vec_t tv[10];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_outs"}, {bus.in_ready, bus.bit_out, bus.bit_valid, bus.cw_last, busy, done}, 6'b0);
    endtask
    task automatic encode(input logic [15:0] d, input logic [5:0] kk, input bit stall,
                          input bit stop_w, input int stop_at, output int len,
                          output logic [63:0] bits, output bit lat, output bit rdy_after,
                          output int frz);
        logic pb, pv, pl;
        bit pstall, fin;
        int t;
        len = 0; bits = '0; frz = 0; fin = 0; pstall = 0; pb = 0; pv = 0; pl = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = d; bus.k = kk; stop = stop_w; bus.bit_ready = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.data_in = ~d; bus.k = ~kk; stop = 1'b0;
        @(negedge clk);
        lat = bus.bit_valid;
        for (int c = 0; c < 400 && !fin; c++) begin
            stop = (c == stop_at);
            bus.bit_ready = stall ? (c % 3 == 0) : 1'b1;
            if (pstall && (bus.bit_out !== pb || bus.bit_valid !== pv || bus.cw_last !== pl)) frz++;
            pstall = !bus.bit_ready; pb = bus.bit_out; pv = bus.bit_valid; pl = bus.cw_last;
            if (bus.bit_valid && bus.bit_ready) begin
                bits = {bits[62:0], bus.bit_out};
                len++;
                fin = bus.cw_last;
            end
            @(negedge clk);
        end
        stop = 1'b0; bus.bit_ready = 1'b1;
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL cw_timeout: cw_last got 0 expected 1");
        end
        rdy_after = bus.in_ready;
    endtask
    initial begin
        int len, frz;
        logic [63:0] bits;
        bit lat, rdy;
        tv[0] = '{16'd13,    6'd2,  0, 6,  64'h5};
        tv[1] = '{16'd0,     6'd0,  0, 1,  64'h1};
        tv[2] = '{16'hFFFF,  6'd0,  0, 50, 64'h1FFFF};
        tv[3] = '{16'd5,     6'd3,  1, 4,  64'hD};
        tv[4] = '{16'd7,     6'd3,  0, 4,  64'hF};
        tv[5] = '{16'hA5A5,  6'd40, 0, 17, 64'h1A5A5};
        tv[6] = '{16'd64,    6'd1,  0, 34, 64'h2};
        tv[7] = '{16'd33,    6'd0,  0, 50, 64'h10021};
        tv[8] = '{16'h8000,  6'd15, 0, 17, 64'h08000};
        tv[9] = '{16'd40,    6'd1,  1, 22, 64'h2};
        bus.in_valid = 1'b0; bus.data_in = '0; bus.k = '0; bus.bit_ready = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        foreach (tv[i]) begin
            encode(tv[i].d, tv[i].k, tv[i].stall, 1'b0, -1, len, bits, lat, rdy, frz);
            chk($sformatf("v%0d_len", i), 64'(len), 64'(tv[i].len));
            chk($sformatf("v%0d_bits", i), bits, tv[i].bits);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd1);
            chk($sformatf("v%0d_ready_after", i), 64'(rdy), 64'd1);
            chk($sformatf("v%0d_frozen", i), 64'(frz), 64'd0);
        end
        encode(16'd40, 6'd1, 1'b0, 1'b0, 5, len, bits, lat, rdy, frz);
        chk("stop_unary_len", 64'(len), 64'd22);
        chk("stop_unary_bits", bits, 64'h2);
        chk("stop_unary_ready", 64'(rdy), 64'd0);
        chk("stop_unary_done", 64'(done), 64'd1);
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("done_sticky", {done, bus.in_ready, bus.bit_valid}, 3'b100);
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset("reset_after_done");
        reset_n = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = 16'd7; bus.k = 6'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rem_pre_reset", {bus.bit_valid, bus.bit_out, bus.cw_last}, 3'b110);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset("reset_mid_rem");
        reset_n = 1'b1;
        encode(16'd7, 6'd3, 1'b0, 1'b0, -1, len, bits, lat, rdy, frz);
        chk("post_reset_len", 64'(len), 64'd4);
        chk("post_reset_bits", bits, 64'hF);
        encode(16'd0, 6'd0, 1'b0, 1'b1, -1, len, bits, lat, rdy, frz);
        chk("stop_idle_len", 64'(len), 64'd1);
        chk("stop_idle_bits", bits, 64'h1);
        chk("stop_idle_done", {done, rdy}, 2'b10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
